// File: rtl/posit_defines.sv
// Shared posit field-width helpers and the registered decode-result record.
package posit_defines;

   typedef enum logic {NORMAL = 1'b0, EXTENDED = 1'b1} pd_mode_e;

   // EXTENDED keeps guard/round/sticky alongside the fraction and one spare scale bit
   function automatic int get_scale_width(input int n, input int es, input pd_mode_e mode);
      return $clog2(n) + es + 1 + ((mode == EXTENDED) ? 1 : 0);
   endfunction

   function automatic int get_fraction_width(input int n, input int es, input pd_mode_e mode);
      return n - es - 3 + ((mode == EXTENDED) ? 3 : 0);
   endfunction

   localparam int PD_N  = 32;
   localparam int PD_ES = 2;
   localparam int PD_SW = get_scale_width(PD_N, PD_ES, NORMAL);
   localparam int PD_FW = get_fraction_width(PD_N, PD_ES, NORMAL);

   typedef struct packed {
      logic                    sign;
      logic                    nar;
      logic                    zero;
      logic signed [PD_SW-1:0] scale;
      logic [PD_FW-1:0]        fraction;
   } pd_fields_t;

endpackage

// File: rtl/pd_control_if.sv
// Connection bundle between a posit word source and the denormalizer.
interface pd_control_if #(
   parameter int N  = 32,
   parameter int ES = 2
);
   localparam int SW = posit_defines::get_scale_width(N, ES, posit_defines::NORMAL);
   localparam int FW = posit_defines::get_fraction_width(N, ES, posit_defines::NORMAL);

   logic [N-1:0]         posit;
   logic                 sign;
   logic                 nar;
   logic                 zero;
   logic signed [SW-1:0] scale;
   logic [FW-1:0]        fraction;

   modport denorm (input posit, output sign, nar, zero, scale, fraction);
   modport user   (output posit, input sign, nar, zero, scale, fraction);
endinterface

// File: rtl/posit_denormalize_I.sv
// Combinational posit decoder: sign/NaR/zero flags, signed scale, left-aligned fraction.
module posit_denormalize_I
   import posit_defines::*;
#(
   parameter int N  = 32,
   parameter int ES = 2
) (
   pd_control_if.denorm ctl
);
   localparam int RW = $clog2(N) + 1;
   localparam int FW = get_fraction_width(N, ES, NORMAL);

   logic [N-1:0]     mag;
   logic             regime_bit;
   logic             run_done;
   logic [RW-1:0]    run_len;
   logic [RW-1:0]    k;
   logic [ES+FW-1:0] tail;

   always_comb begin
      mag        = ctl.posit[N-1] ? -ctl.posit : ctl.posit;
      regime_bit = mag[N-2];
      run_len    = '0;
      run_done   = 1'b0;
      for (int i = N - 2; i >= 0; i--) begin
         if (!run_done && (mag[i] == regime_bit)) run_len = run_len + RW'(1);
         else                                     run_done = 1'b1;
      end
      // The two top magnitude bits are always regime; drop the rest of the run plus terminator
      tail = mag[N-4:0] << (run_len - RW'(1));
      k    = regime_bit ? (run_len - RW'(1)) : -run_len;

      ctl.sign = ctl.posit[N-1];
      ctl.nar  = mag[N-1];
      ctl.zero = ~|ctl.posit;
      if (ctl.nar || ctl.zero) begin
         ctl.scale    = '0;
         ctl.fraction = '0;
      end else begin
         ctl.scale    = $signed({k, tail[ES+FW-1 -: ES]});
         ctl.fraction = tail[FW-1:0];
      end
   end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter; ptr marks the highest-priority position.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   input  logic         en,
   input  logic [N-1:0] ptr,
   output logic [N-1:0] gnt
);
   logic [2*N-1:0] dbl_req;
   logic [2*N-1:0] dbl_gnt;

   // Subtracting the pointer clears the first request at or above it, wrapping via the upper copy
   always_comb begin
      dbl_req = {req, req};
      dbl_gnt = dbl_req & ~(dbl_req - {{N{1'b0}}, ptr});
      gnt     = en ? (dbl_gnt[N-1:0] | dbl_gnt[2*N-1:N]) : '0;
   end
endmodule

// File: rtl/posit_denorm_arbiter.sv
// Round-robin sharing of one posit denormalizer across NUM_REQ producers,
// with a single valid/ready output register carrying the decode and requester ID.
module posit_denorm_arbiter
   import posit_defines::*;
#(
   parameter  int POSIT_WIDTH = 32,
   parameter  int POSIT_ES    = 2,
   parameter  int NUM_REQ     = 4,
   localparam int ID_W        = $clog2(NUM_REQ),
   localparam int SW          = get_scale_width(POSIT_WIDTH, POSIT_ES, NORMAL),
   localparam int FW          = get_fraction_width(POSIT_WIDTH, POSIT_ES, NORMAL)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid_i,
   input  logic [NUM_REQ*POSIT_WIDTH-1:0] req_posit_i,
   output logic [NUM_REQ-1:0]             req_ready_o,
   output logic                           out_valid_o,
   input  logic                           out_ready_i,
   output logic [ID_W-1:0]                out_id_o,
   output logic                           out_sign_o,
   output logic                           out_nar_o,
   output logic                           out_zero_o,
   output logic signed [SW-1:0]           out_scale_o,
   output logic [FW-1:0]                  out_fraction_o,
   output logic [31:0]                    busy_cnt_o
);
   logic                   out_valid_q, out_valid_d;
   logic [ID_W-1:0]        out_id_q, out_id_d;
   pd_fields_t             fields_q, fields_d;
   logic [NUM_REQ-1:0]     last_grant_q, last_grant_d;
   logic [31:0]            busy_cnt_q, busy_cnt_d;

   logic                   slot_free;
   logic                   accept;
   logic [NUM_REQ-1:0]     gnt;
   logic [ID_W-1:0]        gnt_id;
   logic [POSIT_WIDTH-1:0] posit_sel;

   assign slot_free = !out_valid_q || out_ready_i;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req (req_valid_i),
      .en  (slot_free),
      .ptr ({last_grant_q[NUM_REQ-2:0], last_grant_q[NUM_REQ-1]}),
      .gnt (gnt)
   );

   assign accept      = |gnt;
   assign req_ready_o = gnt;

   always_comb begin
      posit_sel = '0;
      gnt_id    = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
         posit_sel = posit_sel | ({POSIT_WIDTH{gnt[r]}} & req_posit_i[r*POSIT_WIDTH +: POSIT_WIDTH]);
         if (gnt[r]) gnt_id = ID_W'(r);
      end
   end

   pd_control_if #(.N(POSIT_WIDTH), .ES(POSIT_ES)) pd_if ();
   assign pd_if.posit = posit_sel;

   posit_denormalize_I #(.N(POSIT_WIDTH), .ES(POSIT_ES)) u_denorm (
      .ctl (pd_if)
   );

   always_comb begin
      out_valid_d  = out_valid_q;
      out_id_d     = out_id_q;
      fields_d     = fields_q;
      last_grant_d = last_grant_q;
      busy_cnt_d   = busy_cnt_q;
      if (accept) begin
         out_valid_d  = 1'b1;
         out_id_d     = gnt_id;
         fields_d     = '{sign: pd_if.sign, nar: pd_if.nar, zero: pd_if.zero,
                          scale: pd_if.scale, fraction: pd_if.fraction};
         last_grant_d = gnt;
         busy_cnt_d   = busy_cnt_q + 32'd1;
      end else if (out_ready_i) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_id_q     <= '0;
         fields_q     <= '0;
         last_grant_q <= {1'b1, {(NUM_REQ-1){1'b0}}};
         busy_cnt_q   <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_id_q     <= out_id_d;
         fields_q     <= fields_d;
         last_grant_q <= last_grant_d;
         busy_cnt_q   <= busy_cnt_d;
      end
   end

   assign out_valid_o    = out_valid_q;
   assign out_id_o       = out_id_q;
   assign out_sign_o     = fields_q.sign;
   assign out_nar_o      = fields_q.nar;
   assign out_zero_o     = fields_q.zero;
   assign out_scale_o    = fields_q.scale;
   assign out_fraction_o = fields_q.fraction;
   assign busy_cnt_o     = busy_cnt_q;
endmodule

// File: tb/tb_posit_denorm_arbiter.sv
// Directed plus randomized bench for posit_denorm_arbiter against a bit-walking posit reference.
module tb_posit_denorm_arbiter;
   localparam int N = 32;
   localparam int R = 4;

   typedef struct {
      logic              s;
      logic              n;
      logic              z;
      logic signed [7:0] sc;
      logic [26:0]       fr;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [R-1:0]      req_valid;
   logic [R*N-1:0]    req_posit;
   logic [R-1:0]      req_ready_o;
   logic              out_valid_o;
   logic              out_ready;
   logic [1:0]        out_id_o;
   logic              out_sign_o, out_nar_o, out_zero_o;
   logic signed [7:0] out_scale_o;
   logic [26:0]       out_fraction_o;
   logic [31:0]       busy_cnt_o;

   int tests  = 0;
   int failed = 0;

   int          m_last;
   bit          m_valid;
   exp_t        m_f;
   int          m_id;
   logic [31:0] m_cnt;
   int          last_g;

   always #5 clk = ~clk;

   posit_denorm_arbiter dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid_i    (req_valid),
      .req_posit_i    (req_posit),
      .req_ready_o    (req_ready_o),
      .out_valid_o    (out_valid_o),
      .out_ready_i    (out_ready),
      .out_id_o       (out_id_o),
      .out_sign_o     (out_sign_o),
      .out_nar_o      (out_nar_o),
      .out_zero_o     (out_zero_o),
      .out_scale_o    (out_scale_o),
      .out_fraction_o (out_fraction_o),
      .busy_cnt_o     (busy_cnt_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv)
      else begin
         failed++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // Reference decode: walk the regime run bit by bit, then read exponent and fraction
   function automatic exp_t mdec(input logic [31:0] w);
      exp_t        e;
      logic [31:0] v;
      logic        r0;
      int          m, i, p, ex, k;
      e.s = w[31]; e.n = (w == 32'h8000_0000); e.z = (w == 32'h0);
      e.sc = '0; e.fr = '0;
      if (!e.n && !e.z) begin
         v  = w[31] ? (32'h0 - w) : w;
         r0 = v[30];
         m  = 0;
         i  = 30;
         while (i >= 0 && v[i] == r0) begin m++; i--; end
         k  = r0 ? m - 1 : -m;
         p  = i - 1;
         ex = 0;
         for (int b = 0; b < 2; b++) ex = ex * 2 + (((p - b) >= 0) ? int'(v[p-b]) : 0);
         for (int b = 0; b < 27; b++) if ((p - 2 - b) >= 0) e.fr[26-b] = v[p-2-b];
         e.sc = 8'(k * 4 + ex);
      end
      return e;
   endfunction

   function automatic int exp_grant();
      int g = -1;
      if (!m_valid || out_ready) begin
         for (int k = 1; k <= R; k++) begin
            int c = (m_last + k) % R;
            if (req_valid[c] && g < 0) g = c;
         end
      end
      return g;
   endfunction

   task automatic model_reset();
      m_last = R - 1; m_valid = 0; m_id = 0; m_cnt = 0;
      m_f = '{s: 1'b0, n: 1'b0, z: 1'b0, sc: 8'sd0, fr: 27'd0};
   endtask

   task automatic check_outputs();
      chk("out_valid", 64'(out_valid_o), 64'(m_valid));
      chk("out_id", 64'(out_id_o), 64'(m_id));
      chk("out_sign", 64'(out_sign_o), 64'(m_f.s));
      chk("out_nar", 64'(out_nar_o), 64'(m_f.n));
      chk("out_zero", 64'(out_zero_o), 64'(m_f.z));
      if (!(m_f.z || m_f.n)) begin
         chk("out_scale", 64'(unsigned'(out_scale_o)), 64'(unsigned'(m_f.sc)));
         chk("out_fraction", 64'(out_fraction_o), 64'(m_f.fr));
      end
      chk("busy_cnt", 64'(busy_cnt_o), 64'(m_cnt));
   endtask

   // One clock: check grant before the edge, advance model, check registered outputs
   task automatic cycle();
      int          g;
      logic [31:0] w;
      #1;
      g = exp_grant();
      chk("req_ready", 64'(req_ready_o), (g < 0) ? 64'd0 : (64'd1 << g));
      w = (g < 0) ? 32'h0 : req_posit[g*N +: N];
      @(posedge clk); #1;
      if (g >= 0) begin
         m_f = mdec(w); m_id = g; m_valid = 1; m_cnt = m_cnt + 1; m_last = g;
      end else if (m_valid && out_ready) begin
         m_valid = 0;
      end
      last_g = g;
      check_outputs();
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] specials [4] = '{32'h0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001};
      if ($urandom_range(0, 7) == 0) return specials[$urandom_range(0, 3)];
      return $urandom;
   endfunction

   logic [31:0] dec_words  [5] = '{32'h4000_0000, 32'h4800_0000, 32'hC000_0000, 32'h0, 32'h8000_0000};
   int          dec_scale  [3] = '{0, 1, 0};
   logic        dec_sign   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   int          rr_seq     [4] = '{3, 1, 3, 1};
   logic [26:0] held_frac;
   logic [7:0]  held_scale;
   logic [1:0]  held_id;

   initial begin
      rst_n = 0; req_valid = '0; req_posit = '0; out_ready = 0; last_g = -1;
      model_reset();
      #3;
      check_outputs();
      @(negedge clk); rst_n = 1;

      // Round-robin with all requesters valid
      out_ready = 1; req_valid = '1;
      for (int r = 0; r < R; r++) req_posit[r*N +: N] = rand_word();
      for (int i = 0; i < 8; i++) begin
         cycle();
         chk("rr_id", 64'(out_id_o), 64'(i % 4));
         req_posit[last_g*N +: N] = rand_word();
      end
      chk("rr_cnt", 64'(busy_cnt_o), 64'd8);
      req_valid = '0; cycle();

      // Directed decode values from requester 2
      for (int i = 0; i < 5; i++) begin
         req_valid = 4'b0100; req_posit[2*N +: N] = dec_words[i];
         cycle();
         chk("dec_id", 64'(out_id_o), 64'd2);
         chk("dec_sign", 64'(out_sign_o), 64'(dec_sign[i]));
         if (i < 3) chk("dec_scale", 64'(unsigned'(out_scale_o)), 64'(unsigned'(8'(dec_scale[i]))));
         if (i < 2) chk("dec_frac", 64'(out_fraction_o), 64'd0);
         if (i == 3) chk("dec_zero", 64'(out_zero_o), 64'd1);
         if (i == 4) chk("dec_nar", 64'(out_nar_o), 64'd1);
      end
      req_valid = '0; cycle();

      // Backpressure with a held result
      req_valid = 4'b0001; req_posit[0 +: N] = 32'h5A5A_1234; cycle();
      held_frac = out_fraction_o; held_scale = out_scale_o; held_id = out_id_o;
      out_ready = 0; req_valid = '1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("bp_frac", 64'(out_fraction_o), 64'(held_frac));
         chk("bp_scale", 64'(held_scale), 64'(unsigned'(out_scale_o)));
         chk("bp_id", 64'(out_id_o), 64'(held_id));
      end
      out_ready = 1; cycle();
      chk("bp_resume_valid", 64'(out_valid_o), 64'd1);
      chk("bp_resume_id", 64'(out_id_o), 64'd1);

      // Sparse fairness: requesters 1 and 3 after last grant = 1
      req_valid = 4'b0010; cycle();
      req_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("sparse_id", 64'(out_id_o), 64'(rr_seq[i]));
      end

      // Randomized traffic; requesters hold until granted
      req_valid = '0;
      for (int i = 0; i < 300; i++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
         for (int r = 0; r < R; r++) begin
            if (!req_valid[r] || r == last_g) begin
               req_valid[r] = $urandom_range(0, 1) == 1;
               req_posit[r*N +: N] = rand_word();
            end
         end
      end

      // Counter wrap
      out_ready = 1; req_valid = '0; cycle();
      @(negedge clk);
      force dut.busy_cnt_q = 32'hFFFF_FFFF;
      #1;
      chk("wrap_forced", 64'(busy_cnt_o), 64'hFFFF_FFFF);
      release dut.busy_cnt_q;
      m_cnt = 32'hFFFF_FFFF;
      req_valid = 4'b0001; req_posit[0 +: N] = 32'h3000_0000;
      cycle();
      chk("wrap_zero", 64'(busy_cnt_o), 64'd0);

      // Asynchronous reset with a result held
      req_valid = '0;
      chk("pre_reset_valid", 64'(out_valid_o), 64'd1);
      @(negedge clk); #2;
      rst_n = 0; #1;
      model_reset();
      check_outputs();
      req_valid = '1;
      @(negedge clk); rst_n = 1;
      cycle();
      chk("post_reset_id", 64'(out_id_o), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
endmodule
